mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit_div_iter.sv | 27 ++
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
//   mdu_op_e    - operation encoding carried on the op port
//   mdu_state_e - FSM state encoding
//   MDU_LATENCY - cycles from the start edge until hi/lo hold the result
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'd0,
      MDU_MULTU = 2'd1,
      MDU_DIV   = 2'd2,
      MDU_DIVU  = 2'd3
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_RUN  = 2'd1,
      MDU_FIX  = 2'd2
   } mdu_state_e;

   localparam int MDU_LATENCY = 33;

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the EX stage and the MDU.
//   master: start, op, a, b, hi_we, lo_we, wdata  -> ; <- busy, done, div_by_zero, hi, lo
//   slave : mirror of master (the unit itself)
interface mul_div_unit_if
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            start;
   mdu_op_e         op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            hi_we;
   logic            lo_we;
   logic [XLEN-1:0] wdata;
   logic            busy;
   logic            done;
   logic            div_by_zero;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mul_div_unit_div_iter.sv
// mdu_div_iter: one combinational restoring-divide step.
//   rem      in  XLEN  partial remainder (always < divisor, so XLEN bits suffice)
//   qin      in  1     next dividend bit shifted into the remainder
//   divisor  in  XLEN  divisor magnitude
//   rem_next out XLEN  remainder after this step
//   qbit     out 1     quotient bit produced by this step
module mdu_div_iter #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic            qin,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic            qbit
);
   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // The shifted remainder needs XLEN+1 bits; a borrow in the top bit of the
   // trial subtraction means the divisor did not fit and the remainder is restored.
   always_comb begin
      shifted  = {rem, qin};
      trial    = shifted - {1'b0, divisor};
      qbit     = ~trial[XLEN];
      rem_next = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
   end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   clk, rst_n  clock, asynchronous active-low reset
//   m (slave)   start/op/a/b launch, hi_we/lo_we/wdata for MTHI/MTLO,
//               busy/done/div_by_zero status, hi/lo architectural registers
// Result lands on hi/lo MDU_LATENCY cycles after the start edge: one load
// edge, ITER radix-2 steps, one sign fix-up edge.
// Build option: define MDU_SIGNED_EN for signed MULT/DIV; without it op[0]
// is ignored and every operation is unsigned.
// ITER must equal XLEN.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = XLEN
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_div_unit_if.slave  m
);
   localparam int CW = $clog2(ITER + 1);

   mdu_state_e        state;
   logic              is_div;
   logic              b_zero;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;     // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [XLEN-1:0]   opnd;    // multiplicand or divisor magnitude
   logic [XLEN-1:0]   raw_a;
   logic              busy_q, done_q, dbz_q;
   logic [XLEN-1:0]   hi_q, lo_q;

   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;

`ifdef MDU_SIGNED_EN
   logic signed_op;
   logic neg_res, neg_rem;

   assign signed_op = ~m.op[0];
   assign a_mag     = (signed_op & m.a[XLEN-1]) ? -m.a : m.a;
   assign b_mag     = (signed_op & m.b[XLEN-1]) ? -m.b : m.b;
   assign prod_fix  = neg_res ? -acc : acc;
   assign quo_fix   = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   // Remainder follows the dividend's sign.
   assign rem_fix   = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
`else
   logic unused_op0;

   assign unused_op0 = m.op[0];
   assign a_mag      = m.a;
   assign b_mag      = m.b;
   assign prod_fix   = acc;
   assign quo_fix    = acc[XLEN-1:0];
   assign rem_fix    = acc[2*XLEN-1:XLEN];
`endif

   // Multiply step: conditionally add multiplicand into the upper half, carry
   // included, then shift the whole accumulator right one bit.
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] mul_next;
   assign add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
   assign mul_next = {add_sum, acc[XLEN-1:1]};

   // Divide step: dividend bits leave the top of the low half, quotient bits
   // enter at the bottom.
   logic [XLEN-1:0]   rem_next;
   logic              qbit;
   logic [2*XLEN-1:0] div_next;

   mdu_div_iter #(.XLEN(XLEN)) u_div_iter (
      .rem      (acc[2*XLEN-1:XLEN]),
      .qin      (acc[XLEN-1]),
      .divisor  (opnd),
      .rem_next (rem_next),
      .qbit     (qbit)
   );
   assign div_next = {rem_next, acc[XLEN-2:0], qbit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= MDU_IDLE;
         is_div  <= 1'b0;
         b_zero  <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         raw_a   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MDU_SIGNED_EN
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            MDU_IDLE: begin
               if (m.start) begin
                  // start beats a same-cycle MTHI/MTLO write
                  state  <= MDU_RUN;
                  busy_q <= 1'b1;
                  is_div <= m.op[1];
                  opnd   <= m.op[1] ? b_mag : a_mag;
                  acc    <= {{XLEN{1'b0}}, (m.op[1] ? a_mag : b_mag)};
                  raw_a  <= m.a;
                  b_zero <= (m.b == '0);
                  dbz_q  <= 1'b0;
                  cnt    <= '0;
`ifdef MDU_SIGNED_EN
                  neg_res <= signed_op & (m.a[XLEN-1] ^ m.b[XLEN-1]);
                  neg_rem <= signed_op & m.a[XLEN-1];
`endif
               end else begin
                  if (m.hi_we) hi_q <= m.wdata;
                  if (m.lo_we) lo_q <= m.wdata;
               end
            end
            MDU_RUN: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(ITER - 1)) state <= MDU_FIX;
            end
            MDU_FIX: begin
               state  <= MDU_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               if (!is_div) begin
                  {hi_q, lo_q} <= prod_fix;
               end else if (b_zero) begin
                  hi_q  <= raw_a;
                  lo_q  <= '1;
                  dbz_q <= 1'b1;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: state <= MDU_IDLE;
         endcase
      end
   end

   assign m.busy        = busy_q;
   assign m.done        = done_q;
   assign m.div_by_zero = dbz_q;
   assign m.hi          = hi_q;
   assign m.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
   import mdu_pkg::*;

   logic clk;
   logic rst_n;
   int   cmp = 0;
   int   mis = 0;

   mul_div_unit_if #(.XLEN(32)) bus ();

   mul_div_unit #(.XLEN(32), .ITER(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives start for one edge (E0); returns #1 after E0.
   task automatic launch(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      step();
      bus.start = 1'b0;
      chk({tag, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
   endtask

   // Counts edges until done, bounded; checks latency, busy length, and busy low with done.
   task automatic wait_done(input int exp_n, input string tag);
      int n  = 0;
      int bc = 0;
      while (bus.done !== 1'b1 && n < 200) begin
         if (bus.busy === 1'b1) bc++;
         step();
         n++;
      end
      chk({tag, "_latency"}, n, exp_n);
      chk({tag, "_busy_len"}, bc, exp_n);
      chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = MDU_MULTU;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      #2;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
      chk("rst_hi",   bus.hi, 32'd0);
      chk("rst_lo",   bus.lo, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // MULTU max * max
      launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
      wait_done(MDU_LATENCY, "multu");
      chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_lo", bus.lo, 32'h0000_0001);
      step();
      chk("multu_done_pulse", {31'd0, bus.done}, 32'd0);

      // MULT -3 * 7
      launch(MDU_MULT, 32'hFFFF_FFFD, 32'd7, "mult");
      wait_done(MDU_LATENCY, "mult");
`ifdef MDU_SIGNED_EN
      chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
`else
      chk("mult_hi", bus.hi, 32'h0000_0006);
`endif
      chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
      step();

      // DIV -7 / 2
      launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div");
      wait_done(MDU_LATENCY, "div");
`ifdef MDU_SIGNED_EN
      chk("div_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_hi", bus.hi, 32'hFFFF_FFFF);
`else
      chk("div_lo", bus.lo, 32'h7FFF_FFFC);
      chk("div_hi", bus.hi, 32'h0000_0001);
`endif
      step();

      // DIV 0x80000000 / -1
      launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
      wait_done(MDU_LATENCY, "divovf");
`ifdef MDU_SIGNED_EN
      chk("divovf_lo", bus.lo, 32'h8000_0000);
      chk("divovf_hi", bus.hi, 32'h0000_0000);
`else
      chk("divovf_lo", bus.lo, 32'h0000_0000);
      chk("divovf_hi", bus.hi, 32'h8000_0000);
`endif
      chk("divovf_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      step();

      // DIVU 100 / 0
      launch(MDU_DIVU, 32'd100, 32'd0, "dbz");
      wait_done(MDU_LATENCY, "dbz");
      chk("dbz_hi",   bus.hi, 32'h0000_0064);
      chk("dbz_lo",   bus.lo, 32'hFFFF_FFFF);
      chk("dbz_flag", {31'd0, bus.div_by_zero}, 32'd1);

      // New start in the done cycle; ignored start/MTHI mid-run
      launch(MDU_MULTU, 32'd5, 32'd6, "mul56");
      chk("mul56_dbz_clr", {31'd0, bus.div_by_zero}, 32'd0);
      repeat (4) step();
      bus.start = 1'b1;
      bus.op    = MDU_DIVU;
      bus.a     = 32'd1;
      bus.b     = 32'd1;
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_1234;
      step();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      chk("mul56_hi_hold", bus.hi, 32'h0000_0064);
      wait_done(MDU_LATENCY - 5, "mul56");
      chk("mul56_hi", bus.hi, 32'd0);
      chk("mul56_lo", bus.lo, 32'd30);
      step();

      // MTHI / MTLO in IDLE
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_1234;
      step();
      bus.hi_we = 1'b0;
      chk("mthi_hi", bus.hi, 32'h0000_1234);
      chk("mthi_lo", bus.lo, 32'd30);
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0000_ABCD;
      step();
      bus.lo_we = 1'b0;
      chk("mtlo_lo", bus.lo, 32'h0000_ABCD);

      // start wins over same-cycle MTLO
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0000_DEAD;
      launch(MDU_MULTU, 32'd2, 32'd3, "mul23");
      bus.lo_we = 1'b0;
      chk("mul23_lo_drop", bus.lo, 32'h0000_ABCD);
      wait_done(MDU_LATENCY, "mul23");
      chk("mul23_lo", bus.lo, 32'd6);
      chk("mul23_hi", bus.hi, 32'd0);
      step();

      // Reset mid-operation
      launch(MDU_DIVU, 32'd1000, 32'd7, "abort");
      repeat (9) step();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_hi",   bus.hi, 32'd0);
      chk("abort_lo",   bus.lo, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      launch(MDU_DIVU, 32'd9, 32'd4, "div94");
      wait_done(MDU_LATENCY, "div94");
      chk("div94_lo", bus.lo, 32'd2);
      chk("div94_hi", bus.hi, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end
endmodule
